hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline control for the 5-stage RV32I core: tracks rd/rs/RegWrite/ResultSrc/MemWrite of E, M, W
//  in an internal shadow pipeline fed from decode-stage control (Main_Decoder outputs).
//  Generates stall, flush and forwarding selects.
//  Sequences data-memory wait states through an FSM with a timeout.
// PARAMETERS
//  REG_AW    5   register address width
//  WAIT_MAX  15  max consecutive mem_ready=0 cycles before mem_timeout (counter width $clog2(WAIT_MAX+1))
// PORTS
//  clk           in   1        core clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  rs1D, rs2D    in   REG_AW   source regs of instr in Decode
//  rdD           in   REG_AW   destination reg of instr in Decode
//  RegWriteD     in   1        decoder RegWrite
//  ResultSrcD    in   1        decoder ResultSrc (1 = load)
//  MemWriteD     in   1        decoder MemWrite
//  PCSrcE        in   1        branch taken, resolved in Execute
//  mem_ready     in   1        dmem completes access in M this cycle
//  StallF/StallD out  1        hold PC / IF-ID register
//  StallE/StallM out  1        hold ID-EX / EX-MEM register
//  FlushD/FlushE out  1        bubble into IF-ID / ID-EX register
//  ForwardAE/BE  out  2        ALU operand select: 00 RF, 10 ALUResultM, 01 ResultW
//  mem_timeout   out  1        sticky; set when wait exceeds WAIT_MAX
// BEHAVIOUR
//  Reset: shadow E/M/W = bubble (RegWrite=0, ResultSrc=0, MemWrite=0, regs=0); FSM=RUN; wait_cnt=0;
//   mem_timeout=0; all outputs 0.
//  Shadow advance (per posedge, when not frozen): E<=D (or bubble if FlushE), M<=E, W<=M.
//   When frozen: E, M hold; W<=bubble.
//  memM = RegWriteM&ResultSrcM | MemWriteM.
//  FSM RUN: memM & !mem_ready -> MEM_WAIT.
//   Freeze asserts combinationally this cycle: StallF=StallD=StallE=StallM=1, Flush*=0.
//  FSM MEM_WAIT: freeze held; wait_cnt++ each cycle. mem_ready=1 -> RUN, wait_cnt=0, advance.
//   wait_cnt==WAIT_MAX & !mem_ready -> set mem_timeout, -> RUN, force advance.
//  Load-use (RUN, not frozen): RegWriteE & ResultSrcE & rdE!=0 & (rdE==rs1D | rdE==rs2D)
//   -> StallF=StallD=1, FlushE=1 for exactly one cycle.
//  Branch (not frozen): PCSrcE -> FlushD=FlushE=1.
//   Overrides load-use: StallF=StallD=0, since the D instr is wrong-path.
//  Priority: freeze > branch > load-use.
//   Branch during freeze is held in E and acted on in the cycle the pipeline advances.
//  Forward A (B identical with rs2E):
//   10 if RegWriteM & rdM!=0 & rdM==rs1E; else 01 if RegWriteW & rdW!=0 & rdW==rs1E; else 00.
//   M beats W. x0 never forwarded. Forward outputs stay valid during freeze.
//  rst mid-MEM_WAIT: immediate return to reset state; the pending access is abandoned.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles with StallF=1) and
//   perf_flush_cnt[31:0] (cycles with FlushE=1).
//   Both reset to 0, wrap at 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package riscv_pkg: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10; OP_LOAD/OP_STORE/OP_RTYPE/OP_ITYPE/OP_BRANCH;
//   state enum {RUN, MEM_WAIT}.
//  Sub-module forward_unit: purely combinational forward select for one operand; instantiated twice.
// TESTING
//  lw x5 then add x6,x5,x1 back-to-back -> StallF=StallD=FlushE=1 for 1 cycle;
//   next cycle ForwardAE=01.
//  add x3 ; sub x4,x3,x3 -> ForwardAE=ForwardBE=10, no stall.
//  rd=x0 load followed by use of x0 -> no stall, Forward=00.
//  PCSrcE=1 coincident with load-use -> FlushD=FlushE=1, StallF=0.
//  lw in M, mem_ready low 3 cycles -> all Stall*=1 for 3 cycles, advance on 4th, mem_timeout=0.
//   Same with mem_ready low 20 cycles -> mem_timeout=1 after 16 wait cycles.
//  rst asserted in MEM_WAIT -> next cycle all outputs 0, FSM RUN.
//   With HAZARD_PERF_EN: counters read 0 after rst.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I pipeline control logic.
package riscv_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // An instruction touches data memory if it is a load (writes RF from memory) or a store.
  function automatic logic is_mem_access(input logic regwrite, input logic resultsrc,
                                         input logic memwrite);
    return (regwrite & resultsrc) | memwrite;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forward select for one ALU operand: M stage beats W stage, x0 never forwarded.
module forward_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  output logic [1:0]        o_fwd
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs_e);
  assign w_hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs_e);

  always_comb begin
    o_fwd = FWD_RF;
    if (w_hit_m) begin
      o_fwd = FWD_M;
    end else if (w_hit_w) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for the 5-stage RV32I core, with a data-memory wait FSM and timeout.
// Optional HAZARD_PERF_EN adds perf_stall_cnt / perf_flush_cnt outputs.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic              RegWriteD,
  input  logic              ResultSrcD,
  input  logic              MemWriteD,
  input  logic              PCSrcE,
  input  logic              mem_ready,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output state_t            o_fsm_state
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX);

  // Shadow pipeline: only the fields hazard detection needs.
  logic [REG_AW-1:0] r_rs1E, r_rs2E, r_rdE;
  logic              r_regwriteE, r_resultsrcE, r_memwriteE;
  logic [REG_AW-1:0] r_rdM;
  logic              r_regwriteM, r_resultsrcM, r_memwriteM;
  logic [REG_AW-1:0] r_rdW;
  logic              r_regwriteW;

  state_t            r_state;
  logic [CW-1:0]     r_wait_cnt;
  logic              r_timeout;

  logic w_mem_m;
  logic w_timeout_now;
  logic w_freeze;
  logic w_branch;
  logic w_load_use;
  logic w_flush_e;

  assign w_mem_m       = is_mem_access(r_regwriteM, r_resultsrcM, r_memwriteM);
  // The last allowed wait cycle releases the pipeline even though memory never answered.
  assign w_timeout_now = (r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LAST) && !mem_ready;
  assign w_freeze      = w_mem_m && !mem_ready && !w_timeout_now;
  assign w_branch      = PCSrcE && !w_freeze;
  assign w_load_use    = (r_state == RUN) && !w_freeze && r_regwriteE && r_resultsrcE &&
                         (r_rdE != '0) && ((r_rdE == rs1D) || (r_rdE == rs2D));
  assign w_flush_e     = w_branch || w_load_use;

  // A taken branch makes the D instruction wrong-path, so it wins over a load-use stall.
  assign StallF      = w_freeze || (w_load_use && !w_branch);
  assign StallD      = w_freeze || (w_load_use && !w_branch);
  assign StallE      = w_freeze;
  assign StallM      = w_freeze;
  assign FlushD      = w_branch;
  assign FlushE      = w_flush_e;
  assign mem_timeout = r_timeout;
  assign o_fsm_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_wait_cnt <= '0;
          if (w_mem_m && !mem_ready) begin
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: begin
          r_state    <= RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1E       <= '0;
      r_rs2E       <= '0;
      r_rdE        <= '0;
      r_regwriteE  <= 1'b0;
      r_resultsrcE <= 1'b0;
      r_memwriteE  <= 1'b0;
      r_rdM        <= '0;
      r_regwriteM  <= 1'b0;
      r_resultsrcM <= 1'b0;
      r_memwriteM  <= 1'b0;
      r_rdW        <= '0;
      r_regwriteW  <= 1'b0;
    end else if (!w_freeze) begin
      if (w_flush_e) begin
        r_rs1E       <= '0;
        r_rs2E       <= '0;
        r_rdE        <= '0;
        r_regwriteE  <= 1'b0;
        r_resultsrcE <= 1'b0;
        r_memwriteE  <= 1'b0;
      end else begin
        r_rs1E       <= rs1D;
        r_rs2E       <= rs2D;
        r_rdE        <= rdD;
        r_regwriteE  <= RegWriteD;
        r_resultsrcE <= ResultSrcD;
        r_memwriteE  <= MemWriteD;
      end
      r_rdM        <= r_rdE;
      r_regwriteM  <= r_regwriteE;
      r_resultsrcM <= r_resultsrcE;
      r_memwriteM  <= r_memwriteE;
      r_rdW        <= r_rdM;
      r_regwriteW  <= r_regwriteM;
    end else begin
      // E and M hold while frozen; W drains so the finished instruction is not written twice.
      r_rdW       <= '0;
      r_regwriteW <= 1'b0;
    end
  end

  forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs_e       (r_rs1E),
    .i_rd_m       (r_rdM),
    .i_rd_w       (r_rdW),
    .i_regwrite_m (r_regwriteM),
    .i_regwrite_w (r_regwriteW),
    .o_fwd        (ForwardAE)
  );

  forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs_e       (r_rs2E),
    .i_rd_m       (r_rdM),
    .i_rd_w       (r_rdW),
    .i_regwrite_m (r_regwriteM),
    .i_regwrite_w (r_regwriteW),
    .o_fwd        (ForwardBE)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (StallF) r_perf_stall <= r_perf_stall + 32'd1;
      if (FlushE) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic
// against an instruction-level model; HAZARD_PERF_EN also checks the perf counters.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int REG_AW   = 5;
  localparam int WAIT_MAX = 15;
`ifdef HAZARD_PERF_EN
  localparam int EW = 76;
`else
  localparam int EW = 12;
`endif

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       rsrc;
    logic       mw;
  } ins_t;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        RegWriteD, ResultSrcD, MemWriteD, PCSrcE, mem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, mem_timeout;
  logic [1:0]  ForwardAE, ForwardBE;
  state_t      fsm_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1D           (rs1D),
    .rs2D           (rs2D),
    .rdD            (rdD),
    .RegWriteD      (RegWriteD),
    .ResultSrcD     (ResultSrcD),
    .MemWriteD      (MemWriteD),
    .PCSrcE         (PCSrcE),
    .mem_ready      (mem_ready),
    .StallF         (StallF),
    .StallD         (StallD),
    .StallE         (StallE),
    .StallM         (StallM),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .mem_timeout    (mem_timeout),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .o_fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  ins_t        m_e, m_m, m_w;
  bit          m_waiting;
  int          m_waited;      // cycles the current M access has already been held
  bit          m_to;
  int unsigned m_stall_cnt, m_flush_cnt;

  ins_t cur_d;
  logic cur_pc, cur_ready;
  logic e_mem_m, e_tmo, e_frz, e_br, e_lu, e_stall_fd, e_flush_e;

  localparam ins_t NOP = '0;

  function automatic ins_t mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    ins_t i;
    i     = '0;
    i.rd  = 5'(rd);
    i.rs1 = 5'(rs1);
    i.rs2 = 5'(rs2);
    case (op)
      OP_LOAD:  {i.rw, i.rsrc, i.mw} = 3'b110;
      OP_STORE: {i.rw, i.rsrc, i.mw} = 3'b001;
      OP_RTYPE: {i.rw, i.rsrc, i.mw} = 3'b100;
      OP_ITYPE: {i.rw, i.rsrc, i.mw} = 3'b100;
      default:  {i.rw, i.rsrc, i.mw} = 3'b000;
    endcase
    return i;
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (m_m.rw && m_m.rd != 0 && m_m.rd == rs) return 2'b10;
    if (m_w.rw && m_w.rd != 0 && m_w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_e = NOP; m_m = NOP; m_w = NOP;
    m_waiting = 0; m_waited = 0; m_to = 0;
    m_stall_cnt = 0; m_flush_cnt = 0;
    e_stall_fd = 0; e_frz = 0; cur_pc = 0; cur_d = NOP;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: apply inputs, queue expectations, wait for the falling edge.
  task automatic drive(input ins_t d, input logic pc, input logic ready);
    logic [EW-1:0] e;
    {rs1D, rs2D, rdD, RegWriteD, ResultSrcD, MemWriteD} = d;
    PCSrcE    = pc;
    mem_ready = ready;
    cur_d = d; cur_pc = pc; cur_ready = ready;

    e_mem_m    = (m_m.rw && m_m.rsrc) || m_m.mw;
    e_tmo      = m_waiting && (m_waited == WAIT_MAX + 1) && !ready;
    e_frz      = e_mem_m && !ready && !e_tmo;
    e_br       = pc && !e_frz;
    e_lu       = !m_waiting && !e_frz && m_e.rw && m_e.rsrc && (m_e.rd != 0) &&
                 (m_e.rd == d.rs1 || m_e.rd == d.rs2);
    e_stall_fd = e_frz || (e_lu && !e_br);
    e_flush_e  = e_br || e_lu;

    e = '0;
    e[1:0]  = fwd_exp(m_e.rs2);
    e[3:2]  = fwd_exp(m_e.rs1);
    e[4]    = e_flush_e;
    e[5]    = e_br;
    e[6]    = e_frz;
    e[7]    = e_frz;
    e[8]    = e_stall_fd;
    e[9]    = e_stall_fd;
    e[10]   = m_to;
    e[11]   = m_waiting;
`ifdef HAZARD_PERF_EN
    e[43:12] = m_stall_cnt;
    e[75:44] = m_flush_cnt;
`endif
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!m_waiting) begin
      if (e_mem_m && !cur_ready) begin m_waiting = 1; m_waited = 1; end
    end else if (cur_ready) begin
      m_waiting = 0; m_waited = 0;
    end else if (e_tmo) begin
      m_to = 1; m_waiting = 0; m_waited = 0;
    end else begin
      m_waited++;
    end
    if (e_stall_fd) m_stall_cnt++;
    if (e_flush_e)  m_flush_cnt++;
    if (!e_frz) begin
      m_w = m_m;
      m_m = m_e;
      m_e = e_flush_e ? NOP : cur_d;
    end else begin
      m_w = NOP;
    end
    #1;
  endtask

  task automatic step(input ins_t d, input logic pc, input logic ready);
    drive(d, pc, ready);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {rs1D, rs2D, rdD, RegWriteD, ResultSrcD, MemWriteD} = NOP;
    PCSrcE = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  // ---------------- compare process ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ForwardBE",   32'(ForwardBE),   32'(e[1:0]));
        check("ForwardAE",   32'(ForwardAE),   32'(e[3:2]));
        check("FlushE",      32'(FlushE),      32'(e[4]));
        check("FlushD",      32'(FlushD),      32'(e[5]));
        check("StallM",      32'(StallM),      32'(e[6]));
        check("StallE",      32'(StallE),      32'(e[7]));
        check("StallD",      32'(StallD),      32'(e[8]));
        check("StallF",      32'(StallF),      32'(e[9]));
        check("mem_timeout", 32'(mem_timeout), 32'(e[10]));
        check("fsm_state",   32'(fsm_state),   32'(e[11]));
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt", perf_stall_cnt, e[43:12]);
        check("perf_flush_cnt", perf_flush_cnt, e[75:44]);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ins_t d;
    logic pc, ready;
    int   burst;
    logic [6:0] ops[5];
    ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_RTYPE; ops[3] = OP_ITYPE; ops[4] = OP_BRANCH;

    rst = 1'b1;
    {rs1D, rs2D, rdD, RegWriteD, ResultSrcD, MemWriteD} = NOP;
    PCSrcE = 1'b0;
    mem_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // reset state
    drive(NOP, 0, 1);
    check("rst_stallF", 32'(StallF), 0);
    check("rst_flushE", 32'(FlushE), 0);
    check("rst_fwdA", 32'(ForwardAE), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    check("rst_state", 32'(fsm_state), 32'(RUN));
    tick();

    // lw x5 ; add x6,x5,x1
    step(mk(OP_LOAD, 5, 2, 0), 0, 1);
    drive(mk(OP_RTYPE, 6, 5, 1), 0, 1);
    check("lu_stallF", 32'(StallF), 1);
    check("lu_stallD", 32'(StallD), 1);
    check("lu_flushE", 32'(FlushE), 1);
    check("lu_stallE", 32'(StallE), 0);
    tick();
    drive(mk(OP_RTYPE, 6, 5, 1), 0, 1);
    check("lu_once_stallF", 32'(StallF), 0);
    check("lu_once_flushE", 32'(FlushE), 0);
    tick();
    drive(NOP, 0, 1);
    check("lu_fwdA", 32'(ForwardAE), 1);
    check("lu_fwdB", 32'(ForwardBE), 0);
    tick();

    // add x3 ; sub x4,x3,x3
    step(mk(OP_RTYPE, 3, 1, 2), 0, 1);
    drive(mk(OP_RTYPE, 4, 3, 3), 0, 1);
    check("alu_stallF", 32'(StallF), 0);
    tick();
    drive(NOP, 0, 1);
    check("alu_fwdA", 32'(ForwardAE), 2);
    check("alu_fwdB", 32'(ForwardBE), 2);
    tick();

    // load to x0 then use of x0
    step(mk(OP_LOAD, 0, 2, 0), 0, 1);
    drive(mk(OP_RTYPE, 7, 0, 0), 0, 1);
    check("x0_stallF", 32'(StallF), 0);
    check("x0_flushE", 32'(FlushE), 0);
    tick();
    drive(NOP, 0, 1);
    check("x0_fwdA", 32'(ForwardAE), 0);
    check("x0_fwdB", 32'(ForwardBE), 0);
    tick();

    // branch coincident with load-use
    step(mk(OP_LOAD, 5, 2, 0), 0, 1);
    drive(mk(OP_RTYPE, 6, 5, 1), 1, 1);
    check("br_flushD", 32'(FlushD), 1);
    check("br_flushE", 32'(FlushE), 1);
    check("br_stallF", 32'(StallF), 0);
    check("br_stallD", 32'(StallD), 0);
    tick();
    repeat (3) step(NOP, 0, 1);

    // mem_ready low for 3 cycles
    step(mk(OP_LOAD, 8, 1, 0), 0, 1);
    step(NOP, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(NOP, 0, 0);
      check("wait3_stallF", 32'(StallF), 1);
      check("wait3_stallM", 32'(StallM), 1);
      tick();
    end
    drive(NOP, 0, 1);
    check("wait3_adv_stallF", 32'(StallF), 0);
    check("wait3_adv_stallM", 32'(StallM), 0);
    check("wait3_timeout", 32'(mem_timeout), 0);
    tick();

    // mem_ready low for 20 cycles
    step(mk(OP_LOAD, 9, 1, 0), 0, 1);
    step(NOP, 0, 1);
    for (int i = 0; i < 16; i++) begin
      drive(NOP, 0, 0);
      check("to_stallM", 32'(StallM), 1);
      tick();
    end
    drive(NOP, 0, 0);
    check("to_release_stallM", 32'(StallM), 0);
    check("to_not_yet", 32'(mem_timeout), 0);
    tick();
    drive(NOP, 0, 0);
    check("to_sticky", 32'(mem_timeout), 1);
    check("to_after_stallM", 32'(StallM), 0);
    tick();
    repeat (2) step(NOP, 0, 0);

    // reset while in MEM_WAIT
    step(mk(OP_LOAD, 10, 1, 0), 0, 1);
    step(NOP, 0, 1);
    step(NOP, 0, 0);
    drive(NOP, 0, 0);
    check("rw_state_wait", 32'(fsm_state), 32'(MEM_WAIT));
    tick();
    do_reset();
    drive(NOP, 0, 1);
    check("rw_state", 32'(fsm_state), 32'(RUN));
    check("rw_stallF", 32'(StallF), 0);
    check("rw_stallM", 32'(StallM), 0);
    check("rw_timeout", 32'(mem_timeout), 0);
`ifdef HAZARD_PERF_EN
    check("rw_perf_stall", perf_stall_cnt, 0);
    check("rw_perf_flush", perf_flush_cnt, 0);
`endif
    tick();

    // randomized traffic
    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      if (e_stall_fd) begin
        d = cur_d;
      end else begin
        d = mk(ops[$urandom_range(0, 4)], $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7));
      end
      pc = e_frz ? cur_pc : ($urandom_range(0, 9) == 0);
      if (burst > 0) begin
        ready = 1'b0;
        burst--;
      end else begin
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(14, 22);
        ready = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 799) == 0) do_reset();
      else step(d, pc, ready);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
